// File: rtl/i2c_reg_writer.sv
// Wishbone master for the OpenCores I2C core: programs the prescaler and enable
// after reset, then runs one polled I2C register write per accepted command.
module i2c_reg_writer #(
    parameter logic [15:0] PRESCALE = 16'd99
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_dev_i,
    input  logic [7:0] cmd_reg_i,
    input  logic [7:0] cmd_dat_i,
    output logic       done_o,
    output logic       nack_o,
    output logic       busy_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [7:0] CTR_EN     = 8'h80;
    localparam logic [7:0] CR_STO     = 8'h40;
    localparam int         SR_RXACK   = 7;
    localparam int         SR_BUSY    = 6;
    localparam int         SR_TIP     = 1;

    typedef enum logic [3:0] {
        ST_INIT_PLO,
        ST_INIT_PHI,
        ST_INIT_CTR,
        ST_IDLE,
        ST_TX,
        ST_CMD,
        ST_POLL,
        ST_CHK,
        ST_ABORT_CR,
        ST_ABORT_POLL,
        ST_FIN
    } state_t;

    state_t     state_r;
    state_t     next_on_ack_s;
    logic [6:0] dev_r;
    logic [7:0] reg_r;
    logic [7:0] dat_r;
    logic [1:0] idx_r;
    logic       rxack_r;
    logic       nack_flag_r;
    logic       stb_r;
    logic       we_r;
    logic [2:0] adr_r;
    logic [7:0] wdat_r;
    logic       ready_r;
    logic       done_r;
    logic       nack_r;
    logic       busy_r;
    logic       is_access_s;
    logic       acc_we_s;
    logic [2:0] acc_adr_s;
    logic [7:0] acc_dat_s;
    logic       unused_dat_bits_s;

    function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [6:0] dev,
                                           input logic [7:0] rg, input logic [7:0] dt);
        case (idx)
            2'd0:    return {dev, 1'b0};
            2'd1:    return rg;
            default: return dt;
        endcase
    endfunction

    // START on the address byte, STOP on the data byte
    function automatic logic [7:0] cr_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h90;
            2'd1:    return 8'h10;
            default: return 8'h50;
        endcase
    endfunction

    // Bus access (address, data, direction) that the current state performs
    always_comb begin
        is_access_s = 1'b1;
        acc_adr_s   = ADR_CR;
        acc_dat_s   = 8'h00;
        acc_we_s    = 1'b1;
        case (state_r)
            ST_INIT_PLO: begin
                acc_adr_s = ADR_PRERLO;
                acc_dat_s = PRESCALE[7:0];
            end
            ST_INIT_PHI: begin
                acc_adr_s = ADR_PRERHI;
                acc_dat_s = PRESCALE[15:8];
            end
            ST_INIT_CTR: begin
                acc_adr_s = ADR_CTR;
                acc_dat_s = CTR_EN;
            end
            ST_TX: begin
                acc_adr_s = ADR_TXR;
                acc_dat_s = tx_byte(idx_r, dev_r, reg_r, dat_r);
            end
            ST_CMD: begin
                acc_dat_s = cr_byte(idx_r);
            end
            ST_POLL, ST_ABORT_POLL: begin
                acc_we_s = 1'b0;
            end
            ST_ABORT_CR: begin
                acc_dat_s = CR_STO;
            end
            default: begin
                is_access_s = 1'b0;
            end
        endcase
    end

    // Successor state taken on the acknowledge of the current access
    always_comb begin
        next_on_ack_s = ST_IDLE;
        case (state_r)
            ST_INIT_PLO: next_on_ack_s = ST_INIT_PHI;
            ST_INIT_PHI: next_on_ack_s = ST_INIT_CTR;
            ST_INIT_CTR: next_on_ack_s = ST_IDLE;
            ST_TX:       next_on_ack_s = ST_CMD;
            ST_CMD:      next_on_ack_s = ST_POLL;
            ST_POLL: begin
                if (wbm_dat_i[SR_TIP]) begin
                    next_on_ack_s = ST_POLL;
                end else begin
                    next_on_ack_s = ST_CHK;
                end
            end
            ST_ABORT_CR: next_on_ack_s = ST_ABORT_POLL;
            ST_ABORT_POLL: begin
                if (wbm_dat_i[SR_BUSY]) begin
                    next_on_ack_s = ST_ABORT_POLL;
                end else begin
                    next_on_ack_s = ST_FIN;
                end
            end
            default:     next_on_ack_s = ST_IDLE;
        endcase
    end

    assign unused_dat_bits_s = ^{wbm_dat_i[5:2], wbm_dat_i[0]};

    // Sequencer: init writes, command acceptance, byte loop, abort and completion
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_r     <= ST_INIT_PLO;
            dev_r       <= 7'd0;
            reg_r       <= 8'd0;
            dat_r       <= 8'd0;
            idx_r       <= 2'd0;
            rxack_r     <= 1'b0;
            nack_flag_r <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= 3'd0;
            wdat_r      <= 8'd0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
            nack_r      <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            done_r <= 1'b0;
            nack_r <= 1'b0;
            if (is_access_s) begin
                // stb low inside an access state means the access has not started;
                // leaving the state on ack gives the mandatory idle cycle
                if (!stb_r) begin
                    stb_r  <= 1'b1;
                    adr_r  <= acc_adr_s;
                    wdat_r <= acc_dat_s;
                    we_r   <= acc_we_s;
                end else if (wbm_ack_i) begin
                    stb_r   <= 1'b0;
                    state_r <= next_on_ack_s;
                    if (state_r == ST_POLL) begin
                        rxack_r <= wbm_dat_i[SR_RXACK];
                    end
                    if ((state_r == ST_ABORT_POLL) && !wbm_dat_i[SR_BUSY]) begin
                        nack_flag_r <= 1'b1;
                    end
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!ready_r) begin
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (cmd_valid_i) begin
                            dev_r   <= cmd_dev_i;
                            reg_r   <= cmd_reg_i;
                            dat_r   <= cmd_dat_i;
                            idx_r   <= 2'd0;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= ST_TX;
                        end
                    end
                    ST_CHK: begin
                        if (rxack_r) begin
                            state_r <= ST_ABORT_CR;
                        end else if (idx_r == 2'd2) begin
                            state_r <= ST_FIN;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            state_r <= ST_TX;
                        end
                    end
                    ST_FIN: begin
                        done_r      <= 1'b1;
                        nack_r      <= nack_flag_r;
                        nack_flag_r <= 1'b0;
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready_o = ready_r;
    assign done_o      = done_r;
    assign nack_o      = nack_r;
    assign busy_o      = busy_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = wdat_r;
    assign wbm_we_o    = we_r;
    assign wbm_stb_o   = stb_r;
    assign wbm_cyc_o   = stb_r;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Bench for i2c_reg_writer: behavioural I2C core + slave model on the Wishbone
// side, transaction-level expectations, and per-cycle output checks.
module tb_i2c_reg_writer;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_dev = 7'd0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_dat = 8'd0;
    logic       done;
    logic       nack;
    logic       busy;
    logic [2:0] adr;
    logic [7:0] wdat;
    logic [7:0] rdat = 8'd0;
    logic       we;
    logic       stb;
    logic       cyc;
    logic       ack = 1'b0;

    int total = 0;
    int bad = 0;

    // core / slave model state
    int         tip_len = 2;
    int         tip_left = 0;
    int         busy_left = 0;
    int         nack_at = -1;
    int         byte_cnt = 0;
    logic [7:0] txr = 8'd0;
    logic       rxack_m = 1'b0;
    int         lat_max = 0;
    bit         stray_en = 1'b0;
    int         wait_cnt = 0;
    int         cur_lat = 0;
    bit         prev_ack = 1'b0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       w0;

    int wr_log[$];
    int ev_log[$];
    int exp_wr[$];
    int exp_ev[$];
    int exp_n[$];
    bit exp_nack[$];

    localparam int EV_START = 'h100;
    localparam int EV_STOP  = 'h200;

    always #5 clk = ~clk;

    i2c_reg_writer #(.PRESCALE(16'd99)) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_dev_i   (cmd_dev),
        .cmd_reg_i   (cmd_reg),
        .cmd_dat_i   (cmd_dat),
        .done_o      (done),
        .nack_o      (nack),
        .busy_o      (busy),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_dat_i   (rdat),
        .wbm_we_o    (we),
        .wbm_stb_o   (stb),
        .wbm_cyc_o   (cyc),
        .wbm_ack_i   (ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // What the I2C core and its slave do when an access is acknowledged
    task automatic serve();
        logic tip_b;
        logic busy_b;
        if (we) begin
            wr_log.push_back(int'({adr, wdat}));
            if (adr == 3'd3) begin
                txr = wdat;
            end else if (adr == 3'd4) begin
                if (wdat[7]) begin
                    ev_log.push_back(EV_START);
                    byte_cnt = 0;
                end
                if (wdat[4]) begin
                    ev_log.push_back(int'(txr));
                    rxack_m = (byte_cnt == nack_at);
                    byte_cnt++;
                    tip_left = tip_len;
                end
                if (wdat[6]) begin
                    ev_log.push_back(EV_STOP);
                    if (!wdat[4]) busy_left = 2;
                end
            end
        end else begin
            check("read_only_sr", int'(adr), 4);
            tip_b  = (tip_left > 0);
            busy_b = tip_b || (busy_left > 0);
            rdat   = {rxack_m, busy_b, 4'b0000, tip_b, 1'b0};
            if (tip_left > 0) tip_left--;
            else if (busy_left > 0) busy_left--;
        end
    endtask

    // Wishbone slave side: ack latency, hold checks, idle-after-ack checks
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!arst_n) begin
                ack = 1'b0; wait_cnt = 0; prev_ack = 1'b0;
                tip_left = 0; busy_left = 0; byte_cnt = 0; rxack_m = 1'b0;
            end else begin
                if (prev_ack) check("idle_after_ack", stb, 1'b0);
                prev_ack = 1'b0;
                if (stb) begin
                    if (wait_cnt == 0) begin
                        a0 = adr; d0 = wdat; w0 = we;
                        cur_lat = int'($urandom_range(lat_max, 0));
                    end else begin
                        check("hold_adr_dat_we", {adr, wdat, we}, {a0, d0, w0});
                    end
                    if (wait_cnt >= cur_lat) begin
                        ack = 1'b1; prev_ack = 1'b1; wait_cnt = 0;
                        serve();
                    end else begin
                        ack = 1'b0; wait_cnt++;
                    end
                end else begin
                    ack = stray_en && ($urandom_range(3, 0) == 0);
                    wait_cnt = 0;
                end
            end
        end
    end

    // Per-cycle compare against the transaction model
    always @(negedge clk) begin
        if (arst_n) begin
            check("cyc_eq_stb", cyc, stb);
            check("busy_vs_ready", busy, !cmd_ready);
            if (done) begin
                check("done_with_ready", cmd_ready, 1'b1);
                check("done_expected", exp_n.size() > 0, 1'b1);
                if (exp_n.size() > 0) begin
                    int n;
                    n = exp_n.pop_front();
                    check("cmd_write_count", wr_log.size(), n);
                    for (int i = 0; i < n; i++) begin
                        if (wr_log.size() > 0) check("cmd_write", wr_log.pop_front(), exp_wr[0]);
                        void'(exp_wr.pop_front());
                    end
                    check("nack", nack, exp_nack.pop_front());
                end
            end
        end
    end

    // Spec-level expectation for one command: writes, slave events, NACK flag
    task automatic expect_cmd(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                              input int nk);
        logic [7:0] b [3];
        logic [7:0] c [3];
        int n;
        n = 0;
        b[0] = {d, 1'b0}; b[1] = r; b[2] = v;
        c[0] = 8'h90; c[1] = 8'h10; c[2] = 8'h50;
        exp_ev.push_back(EV_START);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back(int'({3'd3, b[i]}));
            exp_wr.push_back(int'({3'd4, c[i]}));
            exp_ev.push_back(int'(b[i]));
            n += 2;
            if (i == nk) begin
                exp_wr.push_back(int'({3'd4, 8'h40}));
                n++;
                break;
            end
        end
        exp_ev.push_back(EV_STOP);
        exp_n.push_back(n);
        exp_nack.push_back(nk >= 0 && nk < 3);
    endtask

    task automatic check_events();
        check("ev_count", ev_log.size(), exp_ev.size());
        for (int i = 0; i < ev_log.size() && i < exp_ev.size(); i++)
            check("ev_item", ev_log[i], exp_ev[i]);
        ev_log.delete();
        exp_ev.delete();
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        check("accept_wait", cmd_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_done(output logic nack_seen);
        int n;
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        check("done_seen", done, 1'b1);
        nack_seen = nack;
    endtask

    task automatic run_cmd(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v,
                           input int nk, output logic nack_seen);
        nack_at = nk;
        expect_cmd(d, r, v, nk);
        cmd_dev = d; cmd_reg = r; cmd_dat = v; cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_dat = 8'($urandom);
        wait_done(nack_seen);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    task automatic init_seq();
        int n;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("first_access", {stb, we, adr, wdat}, {1'b1, 1'b1, 3'd0, 8'h63});
        n = 1;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("ready_latency", n, 7);
        check("init_write_count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("init_prerlo", wr_log[0], 'h063);
            check("init_prerhi", wr_log[1], 'h100);
            check("init_ctr", wr_log[2], 'h280);
        end
        wr_log.delete();
        ev_log.delete();
    endtask

    initial begin
        logic ns;
        int n;
        repeat (3) @(negedge clk);
        check("reset_bus", {stb, cyc, we, adr, wdat}, 14'd0);
        check("reset_status", {cmd_ready, done, nack, busy}, 4'b0001);
        init_seq();

        // ACKing slave
        run_cmd(7'h39, 8'h41, 8'h10, -1, ns);
        check("t1_nack", ns, 1'b0);
        check("t1_ev_count", ev_log.size(), 5);
        if (ev_log.size() == 5) begin
            check("t1_start", ev_log[0], EV_START);
            check("t1_dev", ev_log[1], 'h72);
            check("t1_reg", ev_log[2], 'h41);
            check("t1_dat", ev_log[3], 'h10);
            check("t1_stop", ev_log[4], EV_STOP);
        end
        check_events();

        // slave NACKs the register byte
        run_cmd(7'h39, 8'h41, 8'h10, 1, ns);
        check("t2_nack", ns, 1'b1);
        check("t2_ev_count", ev_log.size(), 4);
        if (ev_log.size() == 4) begin
            check("t2_reg", ev_log[2], 'h41);
            check("t2_stop", ev_log[3], EV_STOP);
        end
        check_events();

        // back-to-back with cmd_valid held
        nack_at = -1;
        expect_cmd(7'h39, 8'h41, 8'h10, -1);
        expect_cmd(7'h50, 8'h02, 8'hA5, -1);
        cmd_dev = 7'h39; cmd_reg = 8'h41; cmd_dat = 8'h10; cmd_valid = 1'b1;
        wait_accept();
        cmd_dev = 7'h50; cmd_reg = 8'h02; cmd_dat = 8'hA5;
        wait_done(ns);
        @(negedge clk);
        check("b2b_accept", {cmd_ready, busy}, 2'b01);
        cmd_valid = 1'b0;
        wait_done(ns);
        @(negedge clk);
        check_events();

        // reset while a status poll is on the bus
        nack_at = -1;
        cmd_dev = 7'h22; cmd_reg = 8'h10; cmd_dat = 8'h33; cmd_valid = 1'b1;
        wait_accept();
        cmd_valid = 1'b0;
        n = 0;
        while (!(stb && !we && adr == 3'd4) && n < 500) begin @(negedge clk); n++; end
        check("poll_reached", {stb, we, adr}, {1'b1, 1'b0, 3'd4});
        #2 arst_n = 1'b0;
        #1;
        check("async_reset_bus", {stb, cyc, we, adr, wdat}, 14'd0);
        check("async_reset_status", {cmd_ready, done, nack, busy}, 4'b0001);
        repeat (2) @(negedge clk);
        wr_log.delete();
        ev_log.delete();
        init_seq();

        // ack-latency stress with stray acks while idle
        lat_max = 3;
        stray_en = 1'b1;
        run_cmd(7'h1A, 8'hFE, 8'h01, -1, ns);
        check_events();
        run_cmd(7'h7F, 8'h00, 8'hFF, 0, ns);
        check("t5_dev_nack", ns, 1'b1);
        check_events();
        run_cmd(7'h39, 8'h41, 8'h10, -1, ns);
        check_events();
        lat_max = 0;
        stray_en = 1'b0;
        repeat (4) @(negedge clk);
        check("end_idle", {cmd_ready, busy, stb}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_reg_writer.md
# i2c_reg_writer

Wishbone bus master that sits directly upstream of the OpenCores I2C master wrapper and turns single register-write commands into the core's register-access sequence. After reset it programs the prescaler and enables the core, then accepts commands of the form (7-bit device address, register address, data). For each command it performs a full I2C write (START, device address, register, data, STOP) by polling the core's status register, and reports completion and any NACK. Housekeeping firmware and hardware init sequencers use it to configure video and clock chips without a CPU in the loop.

## Interface
- PRESCALE, 16'd99: value written to PRERhi/PRERlo (wb_clk / (5·SCL) − 1); the default gives 100 kHz at 50 MHz.
- wb_clk_i  in  1  clock; all logic on the rising edge.
- arst_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block can accept a command.
- cmd_dev_i  in  7  I2C 7-bit slave address.
- cmd_reg_i  in  8  target register address.
- cmd_dat_i  in  8  data byte.
- done_o  out  1  one-cycle pulse when a command finishes.
- nack_o  out  1  valid with done_o; 1 means the slave NACKed a byte.
- busy_o  out  1  init or a command is in progress.
- wbm_adr_o  out  3  core register address.
- wbm_dat_o  out  8  write data to the core.
- wbm_dat_i  in  8  read data from the core.
- wbm_we_o  out  1  write enable.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle; always equal to wbm_stb_o.
- wbm_ack_i  in  1  acknowledge from the core.

## Operation
- Core register map: 0 = PRERlo, 1 = PRERhi, 2 = CTR, 3 = TXR (write), 4 = CR (write) / SR (read).
- SR bits: bit7 = RxACK (1 means NACK), bit6 = busy, bit1 = TIP.
- Bus access rules:
  - stb/cyc, adr, we and dat are driven from registers and held stable until wbm_ack_i is sampled high.
  - stb/cyc drop in the cycle after ack; every access is followed by at least one idle cycle.
  - Read data is captured on the ack cycle.
- Init states, entered on reset release:
  - INIT_PLO: write PRESCALE[7:0] to address 0.
  - INIT_PHI: write PRESCALE[15:8] to address 1.
  - INIT_CTR: write 0x80 to address 2.
  - Then go to IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, latch dev/reg/dat, set byte index = 0, go to TX.
- Per-byte loop, byte index 0..2:
  - TX: write TXR with {dev,0}, then reg, then dat.
  - CMD: write CR with 0x90 (STA|WR), 0x10 (WR), or 0x50 (STO|WR) for bytes 0, 1, 2.
  - POLL: read SR repeatedly until TIP = 0.
  - CHK: if RxACK = 1, go to ABORT. Else if byte index = 2, go to FIN. Else increment the index and go to TX.
- ABORT:
  - Write CR = 0x40 (STO).
  - Poll SR until busy = 0 (TIP is not set for a STOP-only command).
  - Set the NACK flag and go to FIN.
- FIN:
  - Pulse done_o; nack_o = the flag.
  - Clear the flag and return to IDLE.
- busy_o = 1 in every state except IDLE.

## Timing
- Reset values:
  - wbm_stb_o, wbm_cyc_o, wbm_we_o = 0; wbm_adr_o = 0; wbm_dat_o = 0.
  - cmd_ready_o = 0, done_o = 0, nack_o = 0, busy_o = 1.
- Asserting arst_i mid-transaction forces those values immediately, even with stb high. Init re-runs after release; the I2C bus state is not repaired (the core is reset on the same net).
- First bus access (INIT_PLO) starts in the first clock after reset release. cmd_ready_o rises the cycle after the CTR ack's idle cycle.
- cmd_ready_o falls in the cycle after acceptance. Command inputs are sampled only on the accept edge.
- done_o/nack_o assert for exactly one cycle, coincident with the first cycle of IDLE. cmd_ready_o is also 1 in that cycle, so back-to-back commands are permitted.
- Polling has no timeout; a stuck TIP holds busy_o indefinitely.
- wbm_ack_i arriving while stb = 0 is ignored.

## Test plan
- Reset, then release with PRESCALE = 99: bus writes are (0,0x63), (1,0x00), (2,0x80) in order, each with one idle cycle after ack, then cmd_ready_o = 1.
- Command dev = 0x39, reg = 0x41, dat = 0x10 against the real core plus an ACKing slave model: the slave sees 0x72, 0x41, 0x10 and a STOP; done_o pulses once; nack_o = 0.
- Same command with the slave NACKing the register byte: CR = 0x40 is written after the second byte; the data byte is never sent; done_o pulses with nack_o = 1.
- Two commands with cmd_valid_i held high: the second is accepted in the done_o cycle; the slave sees two complete transfers with no extra gap.
- Assert arst_i while POLL has stb high: all outputs go to reset values within the same cycle; after release, the init writes repeat.
- Ack-latency stress (a wrapper model delaying wbm_ack_i by 0–3 cycles): adr, dat and we stay stable until ack on every access, and the transfer contents are unchanged.
